// File: rtl/game_timer.sv
// Air-hockey match clock: divides the board clock to a 1 s tick and counts M:SS down to 0:00
// under start/pause/restart button control, flagging end of match.
module game_timer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int START_MIN = 3
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        btn_restart,
    output logic [31:0] m,
    output logic [31:0] s10,
    output logic [31:0] s1,
    output logic        running,
    output logic        done,
    output logic        time_up
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]    MIN_LOAD  = 4'(START_MIN);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    // Button order in the vectors below: [0] start, [1] pause, [2] restart.
    logic [2:0] btn_raw;
    logic [2:0] sync1_reg, sync2_reg, prev_reg;
    logic [2:0] pulse;

    assign btn_raw = {btn_restart, btn_pause, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            always_ff @(posedge clock or negedge ctrl_reset_n) begin
                if (!ctrl_reset_n) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                    prev_reg[gi]  <= 1'b0;
                end else begin
                    sync1_reg[gi] <= btn_raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    prev_reg[gi]  <= sync2_reg[gi];
                end
            end
            assign pulse[gi] = sync2_reg[gi] & ~prev_reg[gi];
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    m_reg, m_next, s10_reg, s10_next, s1_reg, s1_next;
    logic [3:0]    m_dec, s10_dec, s1_dec;
    logic          time_up_reg, time_up_next;
    logic          tick, dec_zero;

    assign tick = (state_reg == RUN) && (presc_reg == PRESC_MAX);

    // BCD borrow chain; minutes cannot underflow because 0:00 ends the match first.
    always_comb begin
        m_dec   = m_reg;
        s10_dec = s10_reg;
        s1_dec  = s1_reg;
        if (s1_reg != 4'd0) begin
            s1_dec = s1_reg - 4'd1;
        end else begin
            s1_dec = 4'd9;
            if (s10_reg != 4'd0) begin
                s10_dec = s10_reg - 4'd1;
            end else begin
                s10_dec = 4'd5;
                m_dec   = m_reg - 4'd1;
            end
        end
    end

    assign dec_zero = (m_dec == 4'd0) && (s10_dec == 4'd0) && (s1_dec == 4'd0);

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        m_next       = m_reg;
        s10_next     = s10_reg;
        s1_next      = s1_reg;
        time_up_next = 1'b0;
        if (pulse[2]) begin
            state_next = IDLE;
            presc_next = '0;
            m_next     = MIN_LOAD;
            s10_next   = 4'd0;
            s1_next    = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pulse[0]) state_next = RUN;
                end
                RUN: begin
                    presc_next = tick ? '0 : presc_reg + 1'b1;
                    if (tick) begin
                        m_next   = m_dec;
                        s10_next = s10_dec;
                        s1_next  = s1_dec;
                    end
                    if (tick && dec_zero) begin
                        state_next   = DONE;
                        time_up_next = 1'b1;
                    end else if (pulse[1]) begin
                        state_next = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pulse[0] || pulse[1]) state_next = RUN;
                end
                DONE: begin
                    state_next = DONE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_reg   <= IDLE;
            presc_reg   <= '0;
            m_reg       <= MIN_LOAD;
            s10_reg     <= 4'd0;
            s1_reg      <= 4'd0;
            time_up_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            m_reg       <= m_next;
            s10_reg     <= s10_next;
            s1_reg      <= s1_next;
            time_up_reg <= time_up_next;
        end
    end

    assign m       = {28'd0, m_reg};
    assign s10     = {28'd0, s10_reg};
    assign s1      = {28'd0, s1_reg};
    assign running = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign time_up = time_up_reg;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a vector table on a 2-minute instance plus hand-written
// expiry, restart-priority and async-reset sequences on a 1-minute instance (CLK_HZ=4).
module tb_game_timer;

    logic        clock = 1'b0;
    logic        rn [2];
    logic        st [2];
    logic        pa [2];
    logic        rs [2];
    logic [31:0] om [2];
    logic [31:0] os10 [2];
    logic [31:0] os1 [2];
    logic        orun [2];
    logic        odone [2];
    logic        otu [2];

    int vectors = 0;
    int miscompares = 0;
    int tu_cnt = 0;

    always #5 clock = ~clock;

    game_timer #(.CLK_HZ(4), .START_MIN(2)) dut_a (
        .clock(clock), .ctrl_reset_n(rn[0]),
        .btn_start(st[0]), .btn_pause(pa[0]), .btn_restart(rs[0]),
        .m(om[0]), .s10(os10[0]), .s1(os1[0]),
        .running(orun[0]), .done(odone[0]), .time_up(otu[0])
    );

    game_timer #(.CLK_HZ(4), .START_MIN(1)) dut_b (
        .clock(clock), .ctrl_reset_n(rn[1]),
        .btn_start(st[1]), .btn_pause(pa[1]), .btn_restart(rs[1]),
        .m(om[1]), .s10(os10[1]), .s1(os1[1]),
        .running(orun[1]), .done(odone[1]), .time_up(otu[1])
    );

    typedef struct {
        bit s, p, r;
        int cyc;
        int em, es10, es1;
        bit er, ed;
        int etu;
    } vec_t;

    vec_t vt [21];

    task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input int d, input int em, input int es10,
                             input int es1, input bit er, input bit ed);
        $display("[%0t] %s dut%0d -> %0d:%0d%0d running=%0b done=%0b time_up=%0b", $time, tag, d,
                 om[d], os10[d], os1[d], orun[d], odone[d], otu[d]);
        chk({tag, ".m"}, om[d], em);
        chk({tag, ".s10"}, os10[d], es10);
        chk({tag, ".s1"}, os1[d], es1);
        chk({tag, ".running"}, 32'(orun[d]), int'(er));
        chk({tag, ".done"}, 32'(odone[d]), int'(ed));
    endtask

    // Called at a negedge: buttons are held for one clock edge, then cyc edges elapse.
    task automatic step(input int d, input bit s, input bit p, input bit r, input int cyc);
        st[d] = s;
        pa[d] = p;
        rs[d] = r;
        repeat (cyc) begin
            @(posedge clock);
            @(negedge clock);
            st[d] = 1'b0;
            pa[d] = 1'b0;
            rs[d] = 1'b0;
            if (otu[d] === 1'b1) tu_cnt++;
        end
    endtask

    initial begin
        //           s  p  r  cyc  m s10 s1 run done tu
        vt[0]  = '{0, 0, 0, 20,  2, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 2,   2, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 1,   2, 0, 0, 1, 0, 0};
        vt[3]  = '{0, 0, 0, 3,   2, 0, 0, 1, 0, 0};
        vt[4]  = '{0, 0, 0, 1,   1, 5, 9, 1, 0, 0};
        vt[5]  = '{0, 0, 0, 4,   1, 5, 8, 1, 0, 0};
        vt[6]  = '{0, 0, 0, 232, 1, 0, 0, 1, 0, 0};
        vt[7]  = '{0, 0, 0, 4,   0, 5, 9, 1, 0, 0};
        vt[8]  = '{0, 0, 0, 3,   0, 5, 9, 1, 0, 0};
        vt[9]  = '{0, 1, 0, 1,   0, 5, 8, 1, 0, 0};
        vt[10] = '{0, 0, 0, 1,   0, 5, 8, 1, 0, 0};
        vt[11] = '{0, 0, 0, 1,   0, 5, 8, 0, 0, 0};
        vt[12] = '{0, 0, 0, 50,  0, 5, 8, 0, 0, 0};
        vt[13] = '{0, 1, 0, 2,   0, 5, 8, 0, 0, 0};
        vt[14] = '{0, 0, 0, 1,   0, 5, 8, 1, 0, 0};
        vt[15] = '{0, 0, 0, 1,   0, 5, 8, 1, 0, 0};
        vt[16] = '{0, 0, 0, 1,   0, 5, 7, 1, 0, 0};
        vt[17] = '{0, 0, 1, 3,   2, 0, 0, 0, 0, 0};
        vt[18] = '{0, 1, 0, 10,  2, 0, 0, 0, 0, 0};
        vt[19] = '{1, 0, 0, 3,   2, 0, 0, 1, 0, 0};
        vt[20] = '{1, 0, 0, 4,   1, 5, 9, 1, 0, 0};

        for (int d = 0; d < 2; d++) begin
            rn[d] = 1'b0;
            st[d] = 1'b0;
            pa[d] = 1'b0;
            rs[d] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check_out("reset_a", 0, 2, 0, 0, 0, 0);
        chk("reset_a.time_up", 32'(otu[0]), 0);
        check_out("reset_b", 1, 1, 0, 0, 0, 0);
        rn[0] = 1'b1;
        rn[1] = 1'b1;

        for (int i = 0; i < 21; i++) begin
            tu_cnt = 0;
            step(0, vt[i].s, vt[i].p, vt[i].r, vt[i].cyc);
            check_out($sformatf("vec%0d", i), 0, vt[i].em, vt[i].es10, vt[i].es1,
                      vt[i].er, vt[i].ed);
            chk($sformatf("vec%0d.time_up_count", i), tu_cnt, vt[i].etu);
        end

        // Expiry: 60 ticks of 4 cycles after the RUN edge.
        tu_cnt = 0;
        step(1, 1, 0, 0, 3);
        check_out("exp_start", 1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 239);
        check_out("exp_0:01", 1, 0, 0, 1, 1, 0);
        chk("exp_pre.time_up_count", tu_cnt, 0);
        step(1, 0, 0, 0, 1);
        check_out("exp_0:00", 1, 0, 0, 0, 0, 1);
        chk("exp_edge.time_up", 32'(otu[1]), 1);
        step(1, 0, 0, 0, 1);
        check_out("exp_after", 1, 0, 0, 0, 0, 1);
        chk("exp_after.time_up", 32'(otu[1]), 0);
        tu_cnt = 0;
        step(1, 1, 0, 0, 5);
        step(1, 0, 1, 0, 5);
        check_out("exp_ignore", 1, 0, 0, 0, 0, 1);
        chk("exp_ignore.time_up_count", tu_cnt, 0);

        // Restart together with pause on the very edge a tick is due at 0:37.
        step(1, 0, 0, 1, 3);
        check_out("rst_from_done", 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 3);
        step(1, 0, 0, 0, 92);
        check_out("run_0:37", 1, 0, 3, 7, 1, 0);
        step(1, 0, 0, 0, 1);
        tu_cnt = 0;
        step(1, 0, 1, 1, 3);
        check_out("restart_prio", 1, 1, 0, 0, 0, 0);
        chk("restart_prio.time_up_count", tu_cnt, 0);
        step(1, 1, 0, 0, 3);
        step(1, 0, 0, 0, 3);
        check_out("resume_presc0", 1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        check_out("resume_tick", 1, 0, 5, 9, 1, 0);
        step(1, 0, 0, 0, 140);
        check_out("run_0:24", 1, 0, 2, 4, 1, 0);

        // Asynchronous reset between edges.
        @(posedge clock);
        #2 rn[1] = 1'b0;
        #1;
        check_out("async_rst", 1, 1, 0, 0, 0, 0);
        chk("async_rst.time_up", 32'(otu[1]), 0);
        @(negedge clock);
        rn[1] = 1'b1;
        step(1, 0, 0, 0, 10);
        check_out("post_rst_idle", 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 3);
        check_out("post_rst_start", 1, 1, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
